// File: rtl/fma3_pack.sv
`default_nettype none
// ============================================================================
//  fma3_pack : final Horner stage, R = C*D + cof0 | cof0 | X, RNE pack to fp32
//  Revision  : 1.0
// ============================================================================
module fma3_pack #(
  parameter int FRAC_WIDTH = 40,
  parameter int EXP_WIDTH  = 8
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_valid,
  input  logic                  i_sel_DorX,
  input  logic                  i_X_ZERO_CAL,
  input  logic                  i_RESULT_SIGN_FLIP,
  input  logic                  i_sign_c,
  input  logic [EXP_WIDTH-1:0]  i_exp_c,
  input  logic [FRAC_WIDTH-1:0] i_frac_c,
  input  logic                  i_sign_cof0,
  input  logic [EXP_WIDTH-1:0]  i_exp_cof0,
  input  logic [FRAC_WIDTH-1:0] i_frac_cof0,
  input  logic                  i_sign_d,
  input  logic [EXP_WIDTH-1:0]  i_exp_d,
  input  logic [31:0]           i_frac_d,
  output logic                  o_valid,
  output logic [31:0]           o_result,
  output logic                  o_ovf,
  output logic                  o_unf
);

  localparam int FW = FRAC_WIDTH;
  localparam int AW = FRAC_WIDTH + 3;
  localparam int XW = 10;
  localparam logic signed [XW-1:0] ZERO_EXP = -10'sd128;

  // ---------------------------------------------------------------- S1
  logic signed [XW-1:0] w_exp_c, w_exp_d, w_exp_0;
  logic [FW:0]          w_prod_hi;
  logic                 w_p_sign;
  logic signed [XW-1:0] w_p_exp;
  logic [FW-1:0]        w_p_frac;

  assign w_exp_c = {{(XW-EXP_WIDTH){i_exp_c[EXP_WIDTH-1]}}, i_exp_c};
  assign w_exp_d = {{(XW-EXP_WIDTH){i_exp_d[EXP_WIDTH-1]}}, i_exp_d};
  assign w_exp_0 = {{(XW-EXP_WIDTH){i_exp_cof0[EXP_WIDTH-1]}}, i_exp_cof0};
  // Top FW+1 product bits; everything below is truncated either way.
  assign w_prod_hi = (FW+1)'(({32'b0, i_frac_c} * {{FW{1'b0}}, i_frac_d}) >> 31);

  always_comb begin
    w_p_sign = i_sign_c ^ i_sign_d;
    if (w_prod_hi[FW]) begin
      w_p_frac = w_prod_hi[FW:1];
      w_p_exp  = w_exp_c + w_exp_d + 10'sd1;
    end else begin
      w_p_frac = w_prod_hi[FW-1:0];
      w_p_exp  = w_exp_c + w_exp_d;
    end
    if (i_frac_c == '0 || i_frac_d == '0) begin
      w_p_frac = '0;
      w_p_exp  = ZERO_EXP;
    end
  end

  logic                 r_v1, r1_sel, r1_xz, r1_flip;
  logic                 r1_p_sign, r1_c0_sign, r1_d_sign;
  logic signed [XW-1:0] r1_p_exp, r1_c0_exp, r1_d_exp;
  logic [FW-1:0]        r1_p_frac, r1_c0_frac, r1_d_frac;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_v1       <= 1'b0;
      r1_sel     <= 1'b0;
      r1_xz      <= 1'b0;
      r1_flip    <= 1'b0;
      r1_p_sign  <= 1'b0;
      r1_p_exp   <= '0;
      r1_p_frac  <= '0;
      r1_c0_sign <= 1'b0;
      r1_c0_exp  <= '0;
      r1_c0_frac <= '0;
      r1_d_sign  <= 1'b0;
      r1_d_exp   <= '0;
      r1_d_frac  <= '0;
    end else begin
      r_v1 <= i_valid;
      if (i_valid) begin
        r1_sel     <= i_sel_DorX;
        r1_xz      <= i_X_ZERO_CAL;
        r1_flip    <= i_RESULT_SIGN_FLIP;
        r1_p_sign  <= w_p_sign;
        r1_p_exp   <= w_p_exp;
        r1_p_frac  <= w_p_frac;
        r1_c0_sign <= i_sign_cof0;
        r1_c0_exp  <= w_exp_0;
        r1_c0_frac <= i_frac_cof0;
        r1_d_sign  <= i_sign_d;
        r1_d_exp   <= w_exp_d;
        r1_d_frac  <= {i_frac_d, {(FW-32){1'b0}}};
      end
    end
  end

  // ---------------------------------------------------------------- S2
  logic                 w_a_big, w_big_s, w_sml_s;
  logic signed [XW-1:0] w_big_e, w_sml_e;
  logic [FW-1:0]        w_big_f, w_sml_f;
  logic [XW:0]          w_diff;
  logic [5:0]           w_sh, w_lzc;
  logic [2*AW-1:0]      w_shx;
  logic [AW-1:0]        w_sml_al;
  logic [AW:0]          w_sum;
  logic [FW-1:0]        w_norm;
  logic                 w_add_s;
  logic signed [XW-1:0] w_add_e;
  logic [FW-1:0]        w_add_f;
  logic                 w_r_s;
  logic signed [XW-1:0] w_r_e;
  logic [FW-1:0]        w_r_f;

  always_comb begin
    w_a_big = (r1_p_exp > r1_c0_exp) ||
              ((r1_p_exp == r1_c0_exp) && (r1_p_frac >= r1_c0_frac));
    w_big_s = w_a_big ? r1_p_sign  : r1_c0_sign;
    w_big_e = w_a_big ? r1_p_exp   : r1_c0_exp;
    w_big_f = w_a_big ? r1_p_frac  : r1_c0_frac;
    w_sml_s = w_a_big ? r1_c0_sign : r1_p_sign;
    w_sml_e = w_a_big ? r1_c0_exp  : r1_p_exp;
    w_sml_f = w_a_big ? r1_c0_frac : r1_p_frac;
    w_diff  = {w_big_e[XW-1], w_big_e} - {w_sml_e[XW-1], w_sml_e};
    w_sh    = (w_diff > 11'd63) ? 6'd63 : w_diff[5:0];
    // Lower half of the shifter catches every bit that falls into sticky.
    w_shx    = {w_sml_f, 3'b000, {AW{1'b0}}} >> w_sh;
    w_sml_al = w_shx[2*AW-1:AW] | {{(AW-1){1'b0}}, |w_shx[AW-1:0]};
    if (w_big_s == w_sml_s) w_sum = {1'b0, w_big_f, 3'b000} + {1'b0, w_sml_al};
    else                    w_sum = {1'b0, w_big_f, 3'b000} - {1'b0, w_sml_al};
    w_lzc = 6'd0;
    for (int i = 0; i < AW; i++) begin
      if (w_sum[i]) w_lzc = 6'(AW - 1 - i);
    end
    w_norm  = FW'((w_sum[AW-1:0] << w_lzc) >> 3);
    w_add_s = w_big_s;
    if (w_sum[AW]) begin
      w_add_f = w_sum[AW:4];
      w_add_e = w_big_e + 10'sd1;
    end else begin
      w_add_f = w_norm;
      w_add_e = w_big_e - $signed({4'b0, w_lzc});
    end
    if (w_sum == '0) begin
      w_add_s = 1'b0;
      w_add_f = '0;
      w_add_e = ZERO_EXP;
    end
    if (r1_p_frac == '0) begin
      w_add_s = r1_c0_sign;
      w_add_e = r1_c0_exp;
      w_add_f = r1_c0_frac;
    end else if (r1_c0_frac == '0) begin
      w_add_s = r1_p_sign;
      w_add_e = r1_p_exp;
      w_add_f = r1_p_frac;
    end

    if (r1_xz) begin
      w_r_s = r1_d_sign;
      w_r_e = r1_d_exp;
      w_r_f = r1_d_frac;
    end else if (r1_sel) begin
      w_r_s = w_add_s;
      w_r_e = w_add_e;
      w_r_f = w_add_f;
    end else begin
      w_r_s = r1_c0_sign;
      w_r_e = r1_c0_exp;
      w_r_f = r1_c0_frac;
    end
  end

  logic                 r_v2, r2_sign;
  logic signed [XW-1:0] r2_exp;
  logic [FW-1:0]        r2_frac;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_v2    <= 1'b0;
      r2_sign <= 1'b0;
      r2_exp  <= '0;
      r2_frac <= '0;
    end else begin
      r_v2 <= r_v1;
      if (r_v1) begin
        r2_sign <= w_r_s ^ r1_flip;
        r2_exp  <= w_r_e;
        r2_frac <= w_r_f;
      end
    end
  end

  // ---------------------------------------------------------------- S3
  logic signed [XW:0] w_biased, w_biased_r;
  logic [22:0]        w_mant;
  logic               w_rnd, w_stk, w_inc;
  logic [23:0]        w_mant_r;
  logic [31:0]        w_res;
  logic               w_ovf, w_unf;

  always_comb begin
    w_biased   = {r2_exp[XW-1], r2_exp} + 11'sd127;
    w_mant     = r2_frac[FW-2 -: 23];
    w_rnd      = r2_frac[FW-25];
    w_stk      = |r2_frac[FW-26:0];
    w_inc      = w_rnd & (w_stk | w_mant[0]);
    w_mant_r   = {1'b0, w_mant} + {23'b0, w_inc};
    w_biased_r = w_biased + {10'b0, w_mant_r[23]};
    w_ovf      = 1'b0;
    w_unf      = 1'b0;
    w_res      = {r2_sign, w_biased_r[7:0], w_mant_r[22:0]};
    if (r2_frac == '0) begin
      w_res = {r2_sign, 31'b0};
    end else if (w_biased <= 11'sd0) begin
      w_res = {r2_sign, 31'b0};
      w_unf = 1'b1;
    end else if (w_biased_r >= 11'sd255) begin
      w_res = {r2_sign, 8'hFF, 23'b0};
      w_ovf = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_valid  <= 1'b0;
      o_result <= '0;
      o_ovf    <= 1'b0;
      o_unf    <= 1'b0;
    end else begin
      o_valid <= r_v2;
      if (r_v2) begin
        o_result <= w_res;
        o_ovf    <= w_ovf;
        o_unf    <= w_unf;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fma3_pack.sv
`default_nettype none
// Directed bench for fma3_pack: hand-computed fp32 results, latency, throughput, reset.
module tb_fma3_pack;

  logic        i_clk = 1'b0;
  logic        i_rstn = 1'b0;
  logic        i_valid = 1'b0;
  logic        i_sel_DorX = 1'b0, i_X_ZERO_CAL = 1'b0, i_RESULT_SIGN_FLIP = 1'b0;
  logic        i_sign_c = 1'b0, i_sign_cof0 = 1'b0, i_sign_d = 1'b0;
  logic [7:0]  i_exp_c = '0, i_exp_cof0 = '0, i_exp_d = '0;
  logic [39:0] i_frac_c = '0, i_frac_cof0 = '0;
  logic [31:0] i_frac_d = '0;
  logic        o_valid, o_ovf, o_unf;
  logic [31:0] o_result;

  int n_checks = 0;
  int n_fail   = 0;

  fma3_pack #(.FRAC_WIDTH(40), .EXP_WIDTH(8)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_valid(i_valid),
    .i_sel_DorX(i_sel_DorX), .i_X_ZERO_CAL(i_X_ZERO_CAL),
    .i_RESULT_SIGN_FLIP(i_RESULT_SIGN_FLIP),
    .i_sign_c(i_sign_c), .i_exp_c(i_exp_c), .i_frac_c(i_frac_c),
    .i_sign_cof0(i_sign_cof0), .i_exp_cof0(i_exp_cof0), .i_frac_cof0(i_frac_cof0),
    .i_sign_d(i_sign_d), .i_exp_d(i_exp_d), .i_frac_d(i_frac_d),
    .o_valid(o_valid), .o_result(o_result), .o_ovf(o_ovf), .o_unf(o_unf)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic        sel, xz, flip;
    logic        sc;
    logic [7:0]  ec;
    logic [39:0] fc;
    logic        s0;
    logic [7:0]  e0;
    logic [39:0] f0;
    logic        sd;
    logic [7:0]  ed;
    logic [31:0] fd;
  } beat_t;

  localparam logic [39:0] ONE40 = 40'h80_0000_0000;
  localparam logic [31:0] ONE32 = 32'h8000_0000;

  function automatic beat_t mk(input logic sel, input logic xz, input logic flip,
                               input logic sc, input logic [7:0] ec, input logic [39:0] fc,
                               input logic s0, input logic [7:0] e0, input logic [39:0] f0,
                               input logic sd, input logic [7:0] ed, input logic [31:0] fd);
    beat_t b;
    b.sel = sel; b.xz = xz; b.flip = flip;
    b.sc = sc; b.ec = ec; b.fc = fc;
    b.s0 = s0; b.e0 = e0; b.f0 = f0;
    b.sd = sd; b.ed = ed; b.fd = fd;
    return b;
  endfunction

  task automatic apply(input beat_t b);
    i_sel_DorX = b.sel; i_X_ZERO_CAL = b.xz; i_RESULT_SIGN_FLIP = b.flip;
    i_sign_c = b.sc; i_exp_c = b.ec; i_frac_c = b.fc;
    i_sign_cof0 = b.s0; i_exp_cof0 = b.e0; i_frac_cof0 = b.f0;
    i_sign_d = b.sd; i_exp_d = b.ed; i_frac_d = b.fd;
  endtask

  // Drives one beat and waits (bounded) for its strobe; lat = -1 on timeout.
  task automatic issue(input beat_t b, output logic [31:0] res, output logic ovf,
                       output logic unf, output int lat);
    @(negedge i_clk);
    apply(b);
    i_valid = 1'b1;
    res = '0; ovf = 1'b0; unf = 1'b0;
    @(negedge i_clk);
    i_valid = 1'b0;
    lat = 1;
    while (!o_valid && lat < 10) begin
      @(negedge i_clk);
      lat++;
    end
    if (o_valid) begin
      res = o_result; ovf = o_ovf; unf = o_unf;
    end else begin
      lat = -1;
    end
  endtask

  // C=1.0, D=2.0, cof0=0.5
  function automatic beat_t b_mac(input logic sel);
    return mk(sel, 1'b0, 1'b0, 1'b0, 8'h00, ONE40, 1'b0, 8'hFF, ONE40, 1'b0, 8'h01, ONE32);
  endfunction

  task automatic test_reset();
    n_checks++;
    if (o_valid !== 1'b0 || o_result !== 32'h0 || o_ovf !== 1'b0 || o_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: valid=%b result=%h ovf=%b unf=%b, required all 0",
               o_valid, o_result, o_ovf, o_unf);
    end
  endtask

  task automatic test_mac();
    logic [31:0] r; logic ov, un; int lat;
    issue(b_mac(1'b1), r, ov, un, lat);
    n_checks++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL mac_latency: got %0d, required 3", lat);
    end
    n_checks++;
    if (r !== 32'h4020_0000 || ov !== 1'b0 || un !== 1'b0) begin
      n_fail++; $display("FAIL mac_result: got %h ovf=%b unf=%b, required 40200000 0 0", r, ov, un);
    end
    @(negedge i_clk);
    n_checks++;
    if (o_valid !== 1'b0) begin
      n_fail++; $display("FAIL mac_strobe_width: valid=%b one cycle later, required 0", o_valid);
    end
  endtask

  task automatic test_select();
    logic [31:0] r; logic ov, un; int lat;
    issue(b_mac(1'b0), r, ov, un, lat);
    n_checks++;
    if (r !== 32'h3F00_0000 || lat !== 3) begin
      n_fail++; $display("FAIL sel_cof0: got %h lat=%0d, required 3f000000 lat=3", r, lat);
    end
  endtask

  task automatic test_xpass();
    logic [31:0] r; logic ov, un; int lat;
    issue(mk(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, ONE40, 1'b0, 8'h00, ONE40, 1'b0, 8'hFF, ONE32),
          r, ov, un, lat);
    n_checks++;
    if (r !== 32'h3F00_0000 || lat !== 3) begin
      n_fail++; $display("FAIL xpass: got %h lat=%0d, required 3f000000 lat=3", r, lat);
    end
    issue(mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, ONE40, 1'b0, 8'h00, ONE40, 1'b0, 8'hFF, ONE32),
          r, ov, un, lat);
    n_checks++;
    if (r !== 32'hBF00_0000 || lat !== 3) begin
      n_fail++; $display("FAIL xpass_flip: got %h lat=%0d, required bf000000 lat=3", r, lat);
    end
  endtask

  task automatic test_round();
    logic [31:0] r; logic ov, un; int lat;
    issue(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, ONE40, 1'b0, 8'h00, 40'h80_0000_8000,
             1'b0, 8'h00, ONE32), r, ov, un, lat);
    n_checks++;
    if (r !== 32'h3F80_0000) begin
      n_fail++; $display("FAIL round_tie_even: got %h, required 3f800000", r);
    end
    issue(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, ONE40, 1'b0, 8'h00, 40'h80_0001_8000,
             1'b0, 8'h00, ONE32), r, ov, un, lat);
    n_checks++;
    if (r !== 32'h3F80_0002) begin
      n_fail++; $display("FAIL round_tie_up: got %h, required 3f800002", r);
    end
  endtask

  task automatic test_cancel();
    logic [31:0] r; logic ov, un; int lat;
    issue(mk(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, ONE40, 1'b1, 8'h00, ONE40, 1'b0, 8'h00, ONE32),
          r, ov, un, lat);
    n_checks++;
    if (r !== 32'h0 || ov !== 1'b0 || un !== 1'b0 || lat !== 3) begin
      n_fail++;
      $display("FAIL cancel: got %h ovf=%b unf=%b lat=%0d, required 00000000 0 0 lat=3",
               r, ov, un, lat);
    end
  endtask

  task automatic test_range();
    logic [31:0] r; logic ov, un; int lat;
    issue(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, ONE40, 1'b0, 8'h7F, 40'hFF_FFFF_FFFF,
             1'b0, 8'h00, ONE32), r, ov, un, lat);
    n_checks++;
    if (r !== 32'h7F80_0000 || ov !== 1'b1 || un !== 1'b0) begin
      n_fail++; $display("FAIL overflow: got %h ovf=%b unf=%b, required 7f800000 1 0", r, ov, un);
    end
    issue(mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, ONE40, 1'b0, 8'h81, ONE40,
             1'b0, 8'h00, ONE32), r, ov, un, lat);
    n_checks++;
    if (r !== 32'h0 || ov !== 1'b0 || un !== 1'b1 || lat !== 3) begin
      n_fail++;
      $display("FAIL underflow: got %h ovf=%b unf=%b lat=%0d, required 00000000 0 1 lat=3",
               r, ov, un, lat);
    end
  endtask

  task automatic test_back_to_back();
    beat_t       bt[4];
    logic [31:0] er[4];
    bt[0] = b_mac(1'b1);
    er[0] = 32'h4020_0000;
    bt[1] = b_mac(1'b0);
    er[1] = 32'h3F00_0000;
    bt[2] = mk(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, ONE40, 1'b0, 8'h00, ONE40, 1'b0, 8'hFF, ONE32);
    er[2] = 32'hBF00_0000;
    bt[3] = mk(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, ONE40, 1'b0, 8'h00, 40'h80_0001_8000,
               1'b0, 8'h00, ONE32);
    er[3] = 32'h3F80_0002;
    @(negedge i_clk);
    for (int t = 0; t < 9; t++) begin
      n_checks++;
      if (t >= 3 && t <= 6) begin
        if (o_valid !== 1'b1 || o_result !== er[t-3]) begin
          n_fail++;
          $display("FAIL b2b_beat%0d: valid=%b result=%h, required valid=1 result=%h",
                   t - 3, o_valid, o_result, er[t-3]);
        end
      end else if (o_valid !== 1'b0) begin
        n_fail++; $display("FAIL b2b_idle_t%0d: valid=%b, required 0", t, o_valid);
      end
      if (t < 4) begin
        apply(bt[t]);
        i_valid = 1'b1;
      end else begin
        i_valid = 1'b0;
      end
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    logic [31:0] r; logic ov, un; int lat;
    @(negedge i_clk);
    apply(b_mac(1'b1));
    i_valid = 1'b1;
    @(negedge i_clk);
    apply(b_mac(1'b0));
    @(negedge i_clk);
    i_valid = 1'b0;
    i_rstn  = 1'b0;
    #1;
    n_checks++;
    if (o_valid !== 1'b0 || o_result !== 32'h0 || o_ovf !== 1'b0 || o_unf !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_reset_outputs: valid=%b result=%h ovf=%b unf=%b, required all 0",
               o_valid, o_result, o_ovf, o_unf);
    end
    @(negedge i_clk);
    i_rstn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge i_clk);
      if (o_valid === 1'b1) seen++;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL midflight_no_valid: saw %0d strobes, required 0", seen);
    end
    issue(b_mac(1'b1), r, ov, un, lat);
    n_checks++;
    if (r !== 32'h4020_0000 || lat !== 3) begin
      n_fail++; $display("FAIL post_reset_mac: got %h lat=%0d, required 40200000 lat=3", r, lat);
    end
  endtask

  initial begin
    repeat (3) @(negedge i_clk);
    test_reset();
    i_rstn = 1'b1;
    @(negedge i_clk);
    test_mac();
    test_select();
    test_xpass();
    test_round();
    test_cancel();
    test_range();
    test_back_to_back();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
